// File: rtl/mem_scheduler.sv
// Arbitrates fetch / load / store-commit requests onto a single byte-serial memory
// controller port: one outstanding request, fixed priority with fetch anti-starvation.
module mem_scheduler #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [31:0] IO_MASK      = 32'h0003_0000,
  parameter int unsigned IO_GUARD     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear_flag_in,
  input  logic        if_fetch_enable_in,
  input  logic [31:0] if_addr_in,
  output logic        if_result_enable_out,
  output logic [31:0] if_data_out,
  input  logic        lb_fetch_enable_in,
  input  logic [31:0] lb_addr_in,
  input  logic [1:0]  lb_len_in,
  output logic        lb_result_enable_out,
  output logic [31:0] lb_data_out,
  input  logic        iq_store_enable_in,
  input  logic [31:0] iq_addr_in,
  input  logic [1:0]  iq_len_in,
  input  logic [31:0] iq_data_in,
  output logic        iq_result_enable_out,
  output logic        mc_req_out,
  output logic        mc_rw_out,
  output logic [31:0] mc_addr_out,
  output logic [1:0]  mc_len_out,
  output logic [31:0] mc_data_out,
  input  logic        mc_done_in,
  input  logic [31:0] mc_data_in,
  input  logic        uart_full_in
);

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic [1:0] {OWN_IF = 2'd0, OWN_LB = 2'd1, OWN_IQ = 2'd2} owner_t;
  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } req_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [3:0] GUARD_INIT = 4'(IO_GUARD);

  state_t      state, state_nxt;
  owner_t      owner;
  logic        p_if, p_lb, p_iq, discard;
  logic [31:0] if_addr_q, lb_addr_q, iq_addr_q, iq_data_q;
  logic [1:0]  lb_len_q, iq_len_q;
  logic [3:0]  starve_cnt, guard_cnt;

  logic idle, lb_busy, iq_busy, kill;
  logic cand_if, cand_lb, cand_iq, iq_io, iq_ok, starved;
  logic grant_if, grant_lb, grant_iq, grant;
  req_t req_if, req_lb, req_iq, req_win;

  function automatic logic [31:0] zext(input logic [31:0] d, input logic [1:0] len);
    case (len)
      2'd0:    zext = {24'd0, d[7:0]};
      2'd1:    zext = {16'd0, d[15:0]};
      default: zext = d;
    endcase
  endfunction

  always_comb begin
    idle    = (state == IDLE);
    lb_busy = !idle && (owner == OWN_LB);
    iq_busy = !idle && (owner == OWN_IQ);
    // a flush kills any fetch/load result, including one completing on the same edge
    kill    = !idle && (owner != OWN_IQ) && (discard || clear_flag_in);

    cand_if = !clear_flag_in && (p_if || if_fetch_enable_in);
    cand_lb = !clear_flag_in && (p_lb || lb_fetch_enable_in);
    cand_iq = p_iq || iq_store_enable_in;

    // fetch bypass takes the newest address; lb/iq repeats while pending are ignored
    req_if = {1'b0, (if_fetch_enable_in ? if_addr_in : if_addr_q), 2'd3, 32'd0};
    req_lb = p_lb ? {1'b0, lb_addr_q, lb_len_q, 32'd0}
                  : {1'b0, lb_addr_in, lb_len_in, 32'd0};
    req_iq = p_iq ? {1'b1, iq_addr_q, iq_len_q, iq_data_q}
                  : {1'b1, iq_addr_in, iq_len_in, iq_data_in};

    iq_io   = (req_iq.addr & IO_MASK) == IO_MASK;
    iq_ok   = cand_iq && !(iq_io && (uart_full_in || guard_cnt != 4'd0));
    starved = cand_if && (starve_cnt == STARVE_MAX);

    grant_if = idle && (starved || (!iq_ok && !cand_lb && cand_if));
    grant_iq = idle && !starved && iq_ok;
    grant_lb = idle && !starved && !iq_ok && cand_lb;
    grant    = grant_if || grant_lb || grant_iq;
    req_win  = grant_iq ? req_iq : (grant_lb ? req_lb : req_if);

    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = WAIT;
      WAIT:    if (mc_done_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state <= IDLE;
    else if (rdy) state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner                <= OWN_IF;
      discard              <= 1'b0;
      p_if                 <= 1'b0;
      p_lb                 <= 1'b0;
      p_iq                 <= 1'b0;
      if_addr_q            <= '0;
      lb_addr_q            <= '0;
      lb_len_q             <= '0;
      iq_addr_q            <= '0;
      iq_len_q             <= '0;
      iq_data_q            <= '0;
      starve_cnt           <= '0;
      guard_cnt            <= '0;
      if_result_enable_out <= 1'b0;
      if_data_out          <= '0;
      lb_result_enable_out <= 1'b0;
      lb_data_out          <= '0;
      iq_result_enable_out <= 1'b0;
      mc_req_out           <= 1'b0;
      mc_rw_out            <= 1'b0;
      mc_addr_out          <= '0;
      mc_len_out           <= '0;
      mc_data_out          <= '0;
    end else if (rdy) begin
      mc_req_out           <= 1'b0;
      if_result_enable_out <= 1'b0;
      lb_result_enable_out <= 1'b0;
      iq_result_enable_out <= 1'b0;
      guard_cnt <= (guard_cnt != 4'd0) ? guard_cnt - 4'd1 : 4'd0;

      if (grant_if || clear_flag_in) p_if <= 1'b0;
      else if (if_fetch_enable_in) begin
        p_if      <= 1'b1;
        if_addr_q <= if_addr_in;
      end

      if (grant_lb || clear_flag_in) p_lb <= 1'b0;
      else if (lb_fetch_enable_in && !p_lb && !lb_busy) begin
        p_lb      <= 1'b1;
        lb_addr_q <= lb_addr_in;
        lb_len_q  <= lb_len_in;
      end

      if (grant_iq) p_iq <= 1'b0;
      else if (iq_store_enable_in && !p_iq && !iq_busy) begin
        p_iq      <= 1'b1;
        iq_addr_q <= iq_addr_in;
        iq_len_q  <= iq_len_in;
        iq_data_q <= iq_data_in;
      end

      if (grant) begin
        mc_req_out  <= 1'b1;
        mc_rw_out   <= req_win.rw;
        mc_addr_out <= req_win.addr;
        mc_len_out  <= req_win.len;
        mc_data_out <= req_win.data;
        owner       <= grant_iq ? OWN_IQ : (grant_lb ? OWN_LB : OWN_IF);
      end

      if (grant_if || clear_flag_in) starve_cnt <= 4'd0;
      else if ((grant_lb || grant_iq) && cand_if && starve_cnt < STARVE_MAX)
        starve_cnt <= starve_cnt + 4'd1;

      if (!idle) begin
        if (mc_done_in) begin
          discard <= 1'b0;
          if (!kill) begin
            case (owner)
              OWN_IF: begin
                if_result_enable_out <= 1'b1;
                if_data_out          <= mc_data_in;
              end
              OWN_LB: begin
                lb_result_enable_out <= 1'b1;
                lb_data_out          <= zext(mc_data_in, mc_len_out);
              end
              OWN_IQ:  iq_result_enable_out <= 1'b1;
              default: ;
            endcase
          end
          if (owner == OWN_IQ && (mc_addr_out & IO_MASK) == IO_MASK)
            guard_cnt <= GUARD_INIT;
        end else if (kill) begin
          discard <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_scheduler.sv
// Bench for mem_scheduler: vector table, directed corner sequences and a random
// phase, all cross-checked every cycle against a transaction-level reference model.
module tb_mem_scheduler;

  localparam int          LIMIT = 4;
  localparam logic [31:0] IOM   = 32'h0003_0000;
  localparam int          GUARD = 2;

  logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, clear = 1'b0;
  logic        if_en = 1'b0, lb_en = 1'b0, iq_en = 1'b0, mc_done = 1'b0, uart_full = 1'b0;
  logic [31:0] if_addr = '0, lb_addr = '0, iq_addr = '0, iq_data = '0, mc_din = '0;
  logic [1:0]  lb_len = '0, iq_len = '0;
  logic        if_res, lb_res, iq_res, mc_req, mc_rw;
  logic [31:0] if_data, lb_data, mc_addr, mc_wdata;
  logic [1:0]  mc_len;

  mem_scheduler #(.STARVE_LIMIT(LIMIT), .IO_MASK(IOM), .IO_GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear_flag_in(clear),
    .if_fetch_enable_in(if_en), .if_addr_in(if_addr),
    .if_result_enable_out(if_res), .if_data_out(if_data),
    .lb_fetch_enable_in(lb_en), .lb_addr_in(lb_addr), .lb_len_in(lb_len),
    .lb_result_enable_out(lb_res), .lb_data_out(lb_data),
    .iq_store_enable_in(iq_en), .iq_addr_in(iq_addr), .iq_len_in(iq_len),
    .iq_data_in(iq_data), .iq_result_enable_out(iq_res),
    .mc_req_out(mc_req), .mc_rw_out(mc_rw), .mc_addr_out(mc_addr),
    .mc_len_out(mc_len), .mc_data_out(mc_wdata),
    .mc_done_in(mc_done), .mc_data_in(mc_din), .uart_full_in(uart_full)
  );

  initial forever #5 clk = ~clk;

  int total = 0, bad = 0;
  bit mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // ---------------- reference model (client 0 = fetch, 1 = load, 2 = store) -------------
  bit          m_pend[3];
  logic [31:0] m_addr[3], m_data[3];
  logic [1:0]  m_len[3];
  bit          m_busy, m_disc;
  int          m_owner, m_starve, m_guard;
  bit          e_req, e_rw;
  bit          e_res[3];
  logic [31:0] e_addr, e_wd, e_ifd, e_lbd;
  logic [1:0]  e_len;

  function automatic bit is_io(input logic [31:0] a);
    return (a & IOM) == IOM;
  endfunction

  function automatic logic [31:0] lmask(input logic [1:0] l);
    return (l == 2'd0) ? 32'h0000_00FF : (l == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 3; c++) begin
      m_pend[c] = 0; m_addr[c] = '0; m_data[c] = '0; m_len[c] = '0; e_res[c] = 0;
    end
    m_busy = 0; m_disc = 0; m_owner = 0; m_starve = 0; m_guard = 0;
    e_req = 0; e_rw = 0; e_addr = '0; e_wd = '0; e_ifd = '0; e_lbd = '0; e_len = '0;
  endtask

  task automatic m_step();
    bit en[3], cand[3];
    logic [31:0] ia[3], id[3], fa[3], fd[3];
    logic [1:0]  il[3], fl[3];
    bit busy0; int own0, win, ng;
    if (!rdy) return;
    en[0] = if_en;  en[1] = lb_en;   en[2] = iq_en;
    ia[0] = if_addr; ia[1] = lb_addr; ia[2] = iq_addr;
    il[0] = 2'd3;    il[1] = lb_len;  il[2] = iq_len;
    id[0] = '0;      id[1] = '0;      id[2] = iq_data;
    for (int c = 0; c < 3; c++) begin
      bit fresh;
      fresh = (c == 0) ? en[0] : !m_pend[c];
      fa[c] = fresh ? ia[c] : m_addr[c];
      fl[c] = fresh ? il[c] : m_len[c];
      fd[c] = fresh ? id[c] : m_data[c];
      e_res[c] = 0;
    end
    busy0 = m_busy; own0 = m_owner; win = -1; e_req = 0;
    ng = (m_guard > 0) ? m_guard - 1 : 0;
    if (busy0) begin
      if (clear && own0 != 2) m_disc = 1;
      if (mc_done) begin
        if (!m_disc) begin
          e_res[own0] = 1;
          if (own0 == 0) e_ifd = mc_din;
          if (own0 == 1) e_lbd = mc_din & lmask(e_len);
        end
        if (own0 == 2 && is_io(e_addr)) ng = GUARD;
        m_busy = 0; m_disc = 0;
      end
    end else begin
      for (int c = 0; c < 3; c++) cand[c] = (m_pend[c] || en[c]) && !(clear && c != 2);
      if (cand[2] && is_io(fa[2]) && (uart_full || m_guard != 0)) cand[2] = 0;
      if (cand[0] && m_starve == LIMIT) win = 0;
      else if (cand[2]) win = 2;
      else if (cand[1]) win = 1;
      else if (cand[0]) win = 0;
      if (win >= 0) begin
        e_req = 1; e_rw = (win == 2); e_addr = fa[win]; e_len = fl[win]; e_wd = fd[win];
        m_busy = 1; m_owner = win; m_pend[win] = 0;
        if (win == 0) m_starve = 0;
        else if (cand[0] && m_starve < LIMIT) m_starve++;
      end
    end
    for (int c = 0; c < 3; c++)
      if (c != win && en[c] && !(clear && c != 2) &&
          (c == 0 || (!m_pend[c] && !(busy0 && own0 == c)))) begin
        m_pend[c] = 1; m_addr[c] = ia[c]; m_len[c] = il[c]; m_data[c] = id[c];
      end
    if (clear) begin m_pend[0] = 0; m_pend[1] = 0; m_starve = 0; end
    m_guard = ng;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else     m_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (mon_on) begin
      chk("mon_req",    mc_req,   e_req);
      chk("mon_rw",     mc_rw,    e_rw);
      chk("mon_addr",   mc_addr,  e_addr);
      chk("mon_len",    mc_len,   e_len);
      chk("mon_wdata",  mc_wdata, e_wd);
      chk("mon_if_res", if_res,   e_res[0]);
      chk("mon_if_dat", if_data,  e_ifd);
      chk("mon_lb_res", lb_res,   e_res[1]);
      chk("mon_lb_dat", lb_data,  e_lbd);
      chk("mon_iq_res", iq_res,   e_res[2]);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic p_if(input logic [31:0] a);
    if_en = 1; if_addr = a; cyc(); if_en = 0;
  endtask
  task automatic p_lb(input logic [31:0] a, input logic [1:0] l);
    lb_en = 1; lb_addr = a; lb_len = l; cyc(); lb_en = 0;
  endtask
  task automatic p_iq(input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
    iq_en = 1; iq_addr = a; iq_len = l; iq_data = d; cyc(); iq_en = 0;
  endtask

  // wait for an issue, capture it, complete it one cycle later
  task automatic serve(input logic [31:0] rd, output logic [31:0] a, output logic rw,
                       output logic [1:0] len, output logic [31:0] wd);
    int n = 0;
    while (mc_req !== 1'b1 && n < 60) begin cyc(); n++; end
    chk("serve_wait", (n < 60), 1);
    a = mc_addr; rw = mc_rw; len = mc_len; wd = mc_wdata;
    cyc(); mc_done = 1; mc_din = rd; cyc(); mc_done = 0;
  endtask

  typedef struct {
    int          cl;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        xrw;
    logic [1:0]  xlen;
    logic [31:0] xdata;
  } vec_t;

  vec_t        vt[8];
  logic [31:0] a, w;
  logic        rw;
  logic [1:0]  ln;

  initial begin
    vt[0] = '{0, 32'h0000_1000, 2'd0, 32'h0,         32'hDEAD_BEEF, 1'b0, 2'd3, 32'hDEAD_BEEF};
    vt[1] = '{1, 32'h0000_2003, 2'd0, 32'h0,         32'h1234_5678, 1'b0, 2'd0, 32'h0000_0078};
    vt[2] = '{1, 32'h0000_2002, 2'd1, 32'h0,         32'h8899_AABB, 1'b0, 2'd1, 32'h0000_AABB};
    vt[3] = '{1, 32'h0000_2000, 2'd3, 32'h0,         32'hCAFE_F00D, 1'b0, 2'd3, 32'hCAFE_F00D};
    vt[4] = '{2, 32'h0000_3000, 2'd1, 32'h0000_BEEF, 32'h0,         1'b1, 2'd1, 32'h0000_BEEF};
    vt[5] = '{2, 32'h0003_0010, 2'd0, 32'h0000_0041, 32'h0,         1'b1, 2'd0, 32'h0000_0041};
    vt[6] = '{2, 32'h0003_0020, 2'd3, 32'h1234_5678, 32'h0,         1'b1, 2'd3, 32'h1234_5678};
    vt[7] = '{1, 32'h0003_0000, 2'd3, 32'h0,         32'hFFFF_FFFF, 1'b0, 2'd3, 32'hFFFF_FFFF};

    // reset state
    repeat (3) cyc();
    chk("rst_req", mc_req, 0);
    chk("rst_addr", mc_addr, 0);
    chk("rst_if_res", if_res, 0);
    chk("rst_lb_dat", lb_data, 0);
    rst = 0;
    mon_on = 1;
    cyc();

    // single fetch with exact latency
    p_if(32'h0000_1000);
    chk("sf_req", mc_req, 1);
    chk("sf_rw", mc_rw, 0);
    chk("sf_len", mc_len, 3);
    chk("sf_addr", mc_addr, 32'h0000_1000);
    repeat (3) cyc();
    mc_done = 1; mc_din = 32'hDEAD_BEEF; cyc(); mc_done = 0;
    chk("sf_res", if_res, 1);
    chk("sf_data", if_data, 32'hDEAD_BEEF);
    cyc();
    chk("sf_res_pulse", if_res, 0);

    // vector table: one transaction per record
    for (int i = 0; i < 8; i++) begin
      case (vt[i].cl)
        0:       p_if(vt[i].addr);
        1:       p_lb(vt[i].addr, vt[i].len);
        default: p_iq(vt[i].addr, vt[i].len, vt[i].wd);
      endcase
      serve(vt[i].rd, a, rw, ln, w);
      chk("vec_addr", a, vt[i].addr);
      chk("vec_rw", rw, vt[i].xrw);
      chk("vec_len", ln, vt[i].xlen);
      if (vt[i].cl == 2) begin
        chk("vec_wdata", w, vt[i].xdata);
        chk("vec_iq_res", iq_res, 1);
      end else if (vt[i].cl == 1) begin
        chk("vec_lb_res", lb_res, 1);
        chk("vec_lb_data", lb_data, vt[i].xdata);
      end else begin
        chk("vec_if_res", if_res, 1);
        chk("vec_if_data", if_data, vt[i].xdata);
      end
    end

    // simultaneous requests: store, load, fetch
    repeat (4) cyc();
    if_en = 1; if_addr = 32'hA00; lb_en = 1; lb_addr = 32'hB00; lb_len = 3;
    iq_en = 1; iq_addr = 32'hC00; iq_len = 3; iq_data = 32'h1;
    cyc(); if_en = 0; lb_en = 0; iq_en = 0;
    serve(32'h11, a, rw, ln, w); chk("sim_1st", a, 32'hC00);
    serve(32'h22, a, rw, ln, w); chk("sim_2nd", a, 32'hB00);
    serve(32'h33, a, rw, ln, w); chk("sim_3rd", a, 32'hA00);

    // fetch starvation: four loads, then the fetch overrides
    if_en = 1; if_addr = 32'h5000; lb_en = 1; lb_addr = 32'h100; lb_len = 3;
    cyc(); if_en = 0; lb_en = 0;
    for (int i = 0; i < 4; i++) begin
      serve(32'h0, a, rw, ln, w);
      chk("starve_load", a, 32'h100 + i);
      p_lb(32'h101 + i, 2'd3);
    end
    serve(32'h55, a, rw, ln, w); chk("starve_fetch", a, 32'h5000);
    serve(32'h66, a, rw, ln, w); chk("starve_load5", a, 32'h104);
    if_en = 1; if_addr = 32'h5100; lb_en = 1; lb_addr = 32'h200; lb_len = 3;
    cyc(); if_en = 0; lb_en = 0;
    serve(32'h0, a, rw, ln, w); chk("starve_rearm", a, 32'h200);
    serve(32'h0, a, rw, ln, w); chk("starve_after", a, 32'h5100);

    // clear during an in-flight fetch; earlier pending store survives
    p_if(32'h2000);
    p_iq(32'h100, 2'd3, 32'h55AA);
    clear = 1; cyc(); clear = 0;
    cyc(); mc_done = 1; mc_din = 32'hBAD0_BAD0; cyc(); mc_done = 0;
    chk("clr_no_res", if_res, 0);
    serve(32'h0, a, rw, ln, w);
    chk("clr_st_addr", a, 32'h100);
    chk("clr_st_rw", rw, 1);
    chk("clr_st_data", w, 32'h55AA);

    // IO store back-pressure and post-completion guard
    uart_full = 1;
    iq_en = 1; iq_addr = 32'h0003_0000; iq_len = 0; iq_data = 32'h41;
    lb_en = 1; lb_addr = 32'h300; lb_len = 3;
    cyc(); iq_en = 0; lb_en = 0;
    serve(32'h7, a, rw, ln, w); chk("io_load_first", a, 32'h300);
    for (int i = 0; i < 3; i++) begin cyc(); chk("io_blocked", mc_req, 0); end
    uart_full = 0;
    serve(32'h0, a, rw, ln, w); chk("io_store", a, 32'h0003_0000);
    begin
      int n = 1;
      iq_en = 1; iq_addr = 32'h0003_0004; iq_len = 0; iq_data = 32'h42;
      cyc(); iq_en = 0;
      while (mc_req !== 1'b1 && n < 20) begin cyc(); n++; end
      chk("io_guard_gap", n, 3);
    end
    serve(32'h0, a, rw, ln, w); chk("io_store2", a, 32'h0003_0004);

    // asynchronous reset mid-request
    p_if(32'h7000);
    #2 rst = 1;
    #1;
    chk("arst_req", mc_req, 0);
    chk("arst_addr", mc_addr, 0);
    chk("arst_if_dat", if_data, 0);
    cyc(); rst = 0;
    mc_done = 1; mc_din = 32'h123; cyc(); mc_done = 0;
    chk("arst_done_ign", if_res, 0);
    p_if(32'h7100);
    serve(32'h77, a, rw, ln, w);
    chk("arst_new_addr", a, 32'h7100);
    chk("arst_new_res", if_res, 1);
    chk("arst_new_data", if_data, 32'h77);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      int l;
      rdy       = ($urandom % 8) != 0;
      clear     = ($urandom % 30) == 0;
      uart_full = ($urandom % 3) == 0;
      if_en     = ($urandom % 6) == 0;
      if_addr   = $urandom & 32'hFFFF_FFFC;
      lb_en     = !m_pend[1] && !(m_busy && m_owner == 1) && ($urandom % 5 == 0);
      lb_addr   = $urandom;
      l = $urandom % 3; lb_len = (l == 2) ? 2'd3 : 2'(l);
      iq_en     = !m_pend[2] && !(m_busy && m_owner == 2) && ($urandom % 5 == 0);
      iq_addr   = ($urandom % 3 == 0) ? (IOM | ($urandom & 32'hFF)) : $urandom;
      l = $urandom % 3; iq_len = (l == 2) ? 2'd3 : 2'(l);
      iq_data   = $urandom;
      mc_done   = (m_busy && !e_req) ? ($urandom % 4 == 0) : ($urandom % 40 == 0);
      mc_din    = $urandom;
      cyc();
    end

    // drain
    rdy = 1; clear = 0; if_en = 0; lb_en = 0; iq_en = 0; uart_full = 0;
    for (int k = 0; k < 80; k++) begin
      mc_done = m_busy && !e_req;
      mc_din  = $urandom;
      cyc();
    end
    mc_done = 0;
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
